// File: rtl/unsplit_pkg.sv
// unsplit_pkg: shared flow-library helpers for the unsplit serializer.
// Only the LOG_* counter-width convention is shared; the state encoding
// stays private to the module.
package unsplit_pkg;

   // Counter width for a slice index over n slices: clog2(n), never below 1.
   function automatic int log_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage : unsplit_pkg

// File: rtl/unsplit.sv
// unsplit: serializes N_IN_STREAMS-slice packed words into one WIDTH-bit
// sample per clock, least-significant slice first. A one-word pending
// buffer absorbs a word arriving mid-drain. A further word is dropped.
// Optional build macro UNSPLIT_ERROR_EN compiles in the sticky overflow
// flag. Without it, error is tied low and overflow drops the word silently.
module unsplit
   import unsplit_pkg::*;
#(
   parameter int N_IN_STREAMS     = 2,
   parameter int LOG_N_IN_STREAMS = log_width(N_IN_STREAMS),
   parameter int WIDTH            = 32
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [WIDTH*N_IN_STREAMS-1:0] in_data,
   input  logic                          in_nd,
   output logic [WIDTH-1:0]              out_data,
   output logic                          out_nd,
   output logic                          error
);

   localparam int WORD_W = WIDTH * N_IN_STREAMS;

   // IDLE: nothing draining. BUSY: sreg holds the word being emitted.
   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   localparam logic [LOG_N_IN_STREAMS-1:0] POS_ONE  = LOG_N_IN_STREAMS'(1);
   localparam logic [LOG_N_IN_STREAMS-1:0] POS_LAST = LOG_N_IN_STREAMS'(N_IN_STREAMS - 1);

   state_t                      state,    state_nx;
   logic [LOG_N_IN_STREAMS-1:0] pos,      pos_nx;
   logic [WORD_W-1:0]           sreg,     sreg_nx;
   logic [WORD_W-1:0]           pend,     pend_nx;
   logic                        pend_v,   pend_v_nx;
   logic [WIDTH-1:0]            out_data_nx;
   logic                        out_nd_nx;
   logic                        error_nx;

   // Next-state and next-output decision for the drain engine.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      state_nx    = state;
      pos_nx      = pos;
      sreg_nx     = sreg;
      pend_nx     = pend;
      pend_v_nx   = pend_v;
      out_data_nx = out_data;
      out_nd_nx   = 1'b0;
`ifdef UNSPLIT_ERROR_EN
      error_nx    = error;
`else
      error_nx    = 1'b0;
`endif

      if (N_IN_STREAMS == 1) begin
         // Single-slice words: a registered pass-through.
         out_data_nx = in_data[WIDTH-1:0];
         out_nd_nx   = in_nd;
      end else begin
         unique case (state)
            IDLE: begin
               if (in_nd) begin
                  // Slice 0 goes straight out; the rest waits in sreg.
                  out_data_nx = in_data[WIDTH-1:0];
                  out_nd_nx   = 1'b1;
                  sreg_nx     = in_data >> WIDTH;
                  pos_nx      = POS_ONE;
                  state_nx    = BUSY;
               end
            end
            BUSY: begin
               out_data_nx = sreg[WIDTH-1:0];
               out_nd_nx   = 1'b1;
               if (pos == POS_LAST) begin
                  // Last slice: refill from pend first, then from the
                  // input, so streaming stays gap-free.
                  pos_nx = '0;
                  if (pend_v) begin
                     sreg_nx   = pend;
                     pend_v_nx = in_nd;
                     if (in_nd) pend_nx = in_data;
                  end else if (in_nd) begin
                     sreg_nx = in_data;
                  end else begin
                     state_nx = IDLE;
                  end
               end else begin
                  pos_nx  = pos + POS_ONE;
                  sreg_nx = sreg >> WIDTH;
                  if (in_nd) begin
                     if (!pend_v) begin
                        pend_nx   = in_data;
                        pend_v_nx = 1'b1;
                     end else begin
                        // Buffer already full: the incoming word is lost.
`ifdef UNSPLIT_ERROR_EN
                        error_nx = 1'b1;
`endif
                     end
                  end
               end
            end
         endcase
      end
   end

   // State, data path and output registers; reset discards any word in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: sreg and pend are single words, not a memory, so they are
         // reset along with the control state to give clean restart values.
         state    <= IDLE;
         pos      <= '0;
         sreg     <= '0;
         pend     <= '0;
         pend_v   <= 1'b0;
         out_data <= '0;
         out_nd   <= 1'b0;
         error    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples the
         // pre-edge values computed above, independent of statement order.
         state    <= state_nx;
         pos      <= pos_nx;
         sreg     <= sreg_nx;
         pend     <= pend_nx;
         pend_v   <= pend_v_nx;
         out_data <= out_data_nx;
         out_nd   <= out_nd_nx;
         error    <= error_nx;
      end
   end

endmodule : unsplit

// File: tb/tb_unsplit.sv
// tb_unsplit: self-checking bench for unsplit. Three instances:
//   a: N=2, WIDTH=32   b: N=4, WIDTH=8   c: N=1, WIDTH=16 (pass-through)
// The reference model treats the output as a FIFO of pending samples: a
// new word is accepted while at most one whole word plus the sample being
// emitted this cycle is still queued; otherwise it overflows.
module tb_unsplit;

`ifdef UNSPLIT_ERROR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   localparam int NA = 2;
   localparam int NB = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic [63:0] a_data = '0;
   logic        a_nd = 1'b0;
   logic [31:0] a_out_data;
   logic        a_out_nd, a_error;

   logic [31:0] b_data = '0;
   logic        b_nd = 1'b0;
   logic [7:0]  b_out_data;
   logic        b_out_nd, b_error;

   logic [15:0] c_data = '0;
   logic        c_nd = 1'b0;
   logic [15:0] c_out_data;
   logic        c_out_nd, c_error;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state.
   logic [31:0] qa[$];
   logic [7:0]  qb[$];
   logic [31:0] ea_data;
   logic        ea_nd, ea_err;
   logic [7:0]  eb_data;
   logic        eb_nd, eb_err;

   always #5 clk = ~clk;

   unsplit #(.N_IN_STREAMS(2), .LOG_N_IN_STREAMS(1), .WIDTH(32)) u_a (
      .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_nd(a_nd),
      .out_data(a_out_data), .out_nd(a_out_nd), .error(a_error));

   unsplit #(.N_IN_STREAMS(4), .LOG_N_IN_STREAMS(2), .WIDTH(8)) u_b (
      .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_nd(b_nd),
      .out_data(b_out_data), .out_nd(b_out_nd), .error(b_error));

   unsplit #(.N_IN_STREAMS(1), .LOG_N_IN_STREAMS(1), .WIDTH(16)) u_c (
      .clk(clk), .rst_n(rst_n), .in_data(c_data), .in_nd(c_nd),
      .out_data(c_out_data), .out_nd(c_out_nd), .error(c_error));

   task automatic clear_model();
      qa.delete();
      qb.delete();
      ea_data = '0; ea_nd = 1'b0; ea_err = 1'b0;
      eb_data = '0; eb_nd = 1'b0; eb_err = 1'b0;
   endtask

   // One clock of instance a: drive, advance the model, compare after the edge.
   task automatic cycle_a(input logic nd, input logic [63:0] word, input string tag);
      a_nd = nd;
      a_data = word;
      if (nd) begin
         if (qa.size() <= NA + 1) begin
            for (int i = 0; i < NA; i++) qa.push_back(word[32*i +: 32]);
         end else if (ERR_EN) begin
            ea_err = 1'b1;
         end
      end
      if (qa.size() != 0) begin
         ea_data = qa.pop_front();
         ea_nd   = 1'b1;
      end else begin
         ea_nd = 1'b0;
      end
      @(posedge clk); #1;
      n_cmp++;
      if (a_out_nd !== ea_nd) begin
         n_bad++; $display("FAIL %s a.out_nd: got %b want %b", tag, a_out_nd, ea_nd);
      end
      n_cmp++;
      if (a_out_data !== ea_data) begin
         n_bad++; $display("FAIL %s a.out_data: got %h want %h", tag, a_out_data, ea_data);
      end
      n_cmp++;
      if (a_error !== ea_err) begin
         n_bad++; $display("FAIL %s a.error: got %b want %b", tag, a_error, ea_err);
      end
   endtask

   // One clock of instance b, same scheme with four 8-bit slices.
   task automatic cycle_b(input logic nd, input logic [31:0] word, input string tag);
      b_nd = nd;
      b_data = word;
      if (nd) begin
         if (qb.size() <= NB + 1) begin
            for (int i = 0; i < NB; i++) qb.push_back(word[8*i +: 8]);
         end else if (ERR_EN) begin
            eb_err = 1'b1;
         end
      end
      if (qb.size() != 0) begin
         eb_data = qb.pop_front();
         eb_nd   = 1'b1;
      end else begin
         eb_nd = 1'b0;
      end
      @(posedge clk); #1;
      n_cmp++;
      if (b_out_nd !== eb_nd) begin
         n_bad++; $display("FAIL %s b.out_nd: got %b want %b", tag, b_out_nd, eb_nd);
      end
      n_cmp++;
      if (b_out_data !== eb_data) begin
         n_bad++; $display("FAIL %s b.out_data: got %h want %h", tag, b_out_data, eb_data);
      end
      n_cmp++;
      if (b_error !== eb_err) begin
         n_bad++; $display("FAIL %s b.error: got %b want %b", tag, b_error, eb_err);
      end
   endtask

   task automatic apply_reset();
      a_nd = 1'b0; b_nd = 1'b0; c_nd = 1'b0;
      rst_n = 1'b0;
      clear_model();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      n_cmp++;
      if ({a_out_nd, a_error, a_out_data} !== 34'd0) begin
         n_bad++; $display("FAIL reset a: got nd=%b err=%b data=%h want zeros", a_out_nd, a_error, a_out_data);
      end
      n_cmp++;
      if ({b_out_nd, b_error, b_out_data} !== 10'd0) begin
         n_bad++; $display("FAIL reset b: got nd=%b err=%b data=%h want zeros", b_out_nd, b_error, b_out_data);
      end
      n_cmp++;
      if ({c_out_nd, c_error, c_out_data} !== 18'd0) begin
         n_bad++; $display("FAIL reset c: got nd=%b err=%b data=%h want zeros", c_out_nd, c_error, c_out_data);
      end
   endtask

   task automatic test_single_word();
      cycle_a(1'b1, 64'h0000000B_0000000A, "single");
      for (int i = 0; i < 4; i++) cycle_a(1'b0, {$urandom, $urandom}, "single");
   endtask

   task automatic test_back_to_back();
      for (int w = 0; w < 3; w++) begin
         cycle_a(1'b1, {32'(2*w + 2), 32'(2*w + 1)}, "b2b");
         cycle_a(1'b0, {$urandom, $urandom}, "b2b");
      end
      for (int i = 0; i < 3; i++) cycle_a(1'b0, '0, "b2b");
   endtask

   task automatic test_burst();
      cycle_a(1'b1, 64'h00000002_00000001, "burst");
      cycle_a(1'b1, 64'h00000004_00000003, "burst");
      for (int i = 0; i < 5; i++) cycle_a(1'b0, {$urandom, $urandom}, "burst");
   endtask

   task automatic test_overflow();
      cycle_b(1'b1, 32'h44332211, "overflow");
      cycle_b(1'b1, 32'h88776655, "overflow");
      cycle_b(1'b1, 32'hDDCCBBAA, "overflow");
      for (int i = 0; i < 10; i++) cycle_b(1'b0, $urandom, "overflow");
   endtask

   task automatic test_reset_mid_word();
      cycle_b(1'b1, 32'hA4A3A2A1, "midreset");
      cycle_b(1'b0, $urandom, "midreset");
      rst_n = 1'b0;
      clear_model();
      #1;
      n_cmp++;
      if (b_out_nd !== 1'b0 || b_out_data !== 8'h00) begin
         n_bad++; $display("FAIL midreset immediate: got nd=%b data=%h want nd=0 data=00", b_out_nd, b_out_data);
      end
      n_cmp++;
      if (b_error !== 1'b0) begin
         n_bad++; $display("FAIL midreset error: got %b want 0", b_error);
      end
      #2;
      rst_n = 1'b1;
      cycle_b(1'b1, 32'hB4B3B2B1, "midreset");
      for (int i = 0; i < 6; i++) cycle_b(1'b0, $urandom, "midreset");
   endtask

   task automatic test_random();
      for (int i = 0; i < 250; i++)
         cycle_a($urandom_range(0, 99) < 45, {$urandom, $urandom}, "rand_a");
      for (int i = 0; i < 8; i++) cycle_a(1'b0, '0, "rand_a");
      for (int i = 0; i < 250; i++)
         cycle_b($urandom_range(0, 99) < 30, $urandom, "rand_b");
      for (int i = 0; i < 12; i++) cycle_b(1'b0, '0, "rand_b");
   endtask

   task automatic test_pass_through();
      logic [15:0] want_data;
      logic        want_nd;
      for (int i = 0; i < 100; i++) begin
         want_nd   = ($urandom_range(0, 1) == 1);
         want_data = 16'($urandom);
         c_nd   = want_nd;
         c_data = want_data;
         @(posedge clk); #1;
         n_cmp++;
         if (c_out_nd !== want_nd || c_out_data !== want_data || c_error !== 1'b0) begin
            n_bad++;
            $display("FAIL pass c: got nd=%b data=%h err=%b want nd=%b data=%h err=0",
                     c_out_nd, c_out_data, c_error, want_nd, want_data);
         end
      end
      c_nd = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_word();
      test_back_to_back();
      test_burst();
      test_overflow();
      test_reset_mid_word();
      test_random();
      test_pass_through();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_unsplit

// File: doc/unsplit.md
# unsplit

Serializes wide packed words back into a single narrow sample stream, one WIDTH-bit sample per clock, stream 0 (least-significant slice) first. It is the inverse of the flow-library split stage and sits at the far end of a parallel-lane section, returning N parallel lanes to one serial datapath. A one-word pending buffer absorbs a new word that arrives while the previous one is still draining. Overflow beyond that buffer is flagged.

## Interface
- N_IN_STREAMS, 2, number of WIDTH-bit slices per input word (≥1)
- LOG_N_IN_STREAMS, 1, counter width; ≥ clog2(N_IN_STREAMS), minimum 1
- WIDTH, 32, bits per output sample
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  WIDTH*N_IN_STREAMS  packed word; slice i = bits [WIDTH*(i+1)-1 : WIDTH*i]
- in_nd  input  1  in_data valid this cycle
- out_data  output  WIDTH  current serial sample (registered)
- out_nd  output  1  out_data valid this cycle (registered)
- error  output  1  sticky overflow flag (registered)

## Operation
- Reset (rst_n low, asynchronous): out_data=0, out_nd=0, error=0, pos=0, state IDLE, pending empty.
- Storage:
  - shift register sreg holds the word being drained;
  - pos counts slices emitted, 0..N_IN_STREAMS-1;
  - pend/pend_v form the one-word buffer.
- State IDLE:
  - in_nd=1: emit slice 0 of in_data, load remaining slices into sreg, pos←1.
  - If N_IN_STREAMS>1, go to BUSY; otherwise stay in IDLE.
  - in_nd=0: out_nd←0.
- State BUSY, each cycle: emit next slice from sreg, out_nd←1, pos←pos+1.
- Last-slice cycle (pos==N_IN_STREAMS-1), next state chosen in this priority:
  - pend_v=1: load pend into sreg, pos←0, stay BUSY. If in_nd also high, in_data goes into pend (pend_v stays 1).
  - pend_v=0 and in_nd=1: load in_data into sreg directly, pos←0, stay BUSY. This gives gap-free streaming.
  - Otherwise pos←0, go to IDLE.
- in_nd=1 in BUSY on a non-last cycle:
  - pend_v=0: store the word in pend, pend_v←1.
  - pend_v=1: overflow. The incoming word is dropped and pend is unchanged.
- N_IN_STREAMS=1: pass-through, out_data←in_data, out_nd←in_nd; pend is never used.
- out_data holds its last value while out_nd=0.

## Timing
- Latency: in_nd sampled at edge k gives out_nd high on cycles k+1 … k+N_IN_STREAMS, with slices 0..N-1 in order.
- Sustained throughput: one word per N_IN_STREAMS cycles with continuous out_nd.
- Burst tolerance: one extra word mid-drain is accepted. A second extra word before the buffer frees is an overflow.
- error rises the cycle after the overflowing edge and stays high until reset.
- Reset asserted mid-word: output stops immediately, and sreg and pend are discarded. The first in_nd after release starts a fresh word at slice 0.

## Configuration
- UNSPLIT_ERROR_EN
  - Defined: overflow detection is compiled in and error behaves as above.
  - Not defined: overflow logic is removed and error is tied to 0. Overflow still drops the incoming word silently.

## Structure
- State encoding (IDLE, BUSY) lives as localparams inside the module.
- No typedefs belong in a shared package. Only the flow-library convention of a LOG_* width parameter is shared.
- No sub-module is needed: one always block for the sequential logic, plus a combinational slice select on sreg[WIDTH-1:0] with a right shift by WIDTH per emit.

## Test plan
- Reset, then single word: in_data=0x0000000B_0000000A, in_nd for 1 cycle → out_data 0x0A then 0x0B with out_nd high for exactly 2 cycles, then low; error=0.
- Back-to-back every 2 cycles: words {0x2,0x1}, {0x4,0x3}, {0x6,0x5} → continuous out_nd for 6 cycles carrying 1,2,3,4,5,6.
- Burst buffering: in_nd on 2 consecutive cycles with {0x2,0x1} and {0x4,0x3} → output 1,2,3,4 contiguous; error=0.
- Overflow (N=4, WIDTH=8): in_nd on 3 consecutive cycles with words W0, W1, W2 → W0 then W1 emitted (8 samples), W2 dropped, error=1 from the cycle after W2 and held. Without UNSPLIT_ERROR_EN, error stays 0.
- Reset mid-word (N=4): assert rst_n=0 after 2 slices have been emitted → out_nd=0 and out_data=0 immediately. After release, a new word emits its slice 0 first.
- Pass-through (N=1, LOG=1): random in_nd/in_data → out_data and out_nd equal the inputs delayed by one cycle.
